fetch_prefetch_unit: RTL and testbench

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

---
 rtl/fetch_prefetch_unit.sv | 96 +++++++++
 tb/tb_fetch_prefetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch queue: one outstanding imem read at a time, results buffered
// in a DEPTH-entry {pc, ir} ring that feeds the IF/ID register.
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  output logic [31:0] out_ir,
  output logic [31:0] out_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t         state, state_next;
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count, count_next;
  logic [31:0]    fetch_pc, fetch_pc_next;
  logic           push, pop, req_next;
  logic [31:0]    pc_q [DEPTH];
  logic [31:0]    ir_q [DEPTH];

  assign push          = (state == FETCH) && imem_ack && !redirect;
  assign pop           = (count != '0) && !hold && !redirect;
  assign count_next    = count + CW'(push) - CW'(pop);
  assign fetch_pc_next = redirect ? redirect_pc : (push ? fetch_pc + 32'd4 : fetch_pc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!redirect && count_next < DEPTH_C) state_next = FETCH;
      FETCH: begin
        // A redirect while the read is still pending must wait out the stale ack.
        if (redirect)      state_next = imem_ack ? IDLE : DRAIN;
        else if (imem_ack) state_next = (count_next < DEPTH_C) ? FETCH : IDLE;
      end
      DRAIN:   if (imem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_next  = (state_next != IDLE);
    out_valid = (count != '0);
    out_ir    = out_valid ? ir_q[rd_ptr] : 32'h0;
    out_pc    = out_valid ? pc_q[rd_ptr] : 32'h0;
  end

  // imem_addr only follows fetch_pc when a FETCH is (re)issued, so DRAIN keeps the stale address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      imem_req <= req_next;
      fetch_pc <= fetch_pc_next;
      if (state_next == FETCH) imem_addr <= fetch_pc_next;
      if (redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count_next;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr] <= fetch_pc;
      ir_q[wr_ptr] <= imem_data;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: behavioural imem with programmable latency,
// outputs sampled on the falling edge, inputs driven there too.
module tb_fetch_prefetch_unit;
  logic        clk = 1'b0;
  logic        reset, redirect, hold;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic        out_valid;
  logic [31:0] out_ir, out_pc;

  int n_cmp = 0;
  int n_err = 0;
  int lat = 0;
  logic force_ack = 1'b0;

  fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc), .hold(hold),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .out_valid(out_valid), .out_ir(out_ir), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Memory: acks a request after it has been pending for lat cycles.
  initial begin
    int age;
    age = 0;
    imem_ack = 1'b0;
    imem_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!imem_req) age = 0;
      imem_ack  = force_ack || (imem_req && age >= lat);
      imem_data = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      if (imem_ack)      age = 0;
      else if (imem_req) age++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] hpat;
    logic [31:0] exp_pc;
    int pops;
    reset = 1'b0; redirect = 1'b0; hold = 1'b0; redirect_pc = 32'h0;
    force_ack = 1'b1;

    // Reset state, with a spurious ack that must be ignored
    tick(3);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ir", out_ir, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    force_ack = 1'b0;
    tick(2);
    reset = 1'b1;

    // Zero-wait streaming
    tick;
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", out_valid, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_pc", out_pc, 32'(4 * k));
      chk("stream_ir", out_ir, mem_word(32'(4 * k)));
    end

    // Hold fills the queue, then release drains one per cycle
    redirect = 1'b1; redirect_pc = 32'h0; hold = 1'b1;
    tick;
    redirect = 1'b0;
    chk("hold_flush", out_valid, 1'b0);
    tick(9);
    chk("hold_req", imem_req, 1'b0);
    chk("hold_valid", out_valid, 1'b1);
    chk("hold_head", out_pc, 32'h0);
    chk("hold_ir", out_ir, mem_word(32'h0));
    hold = 1'b0;
    tick;
    chk("rel_pc1", out_pc, 32'h4);
    chk("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, 32'h10);
    tick;
    chk("rel_pc2", out_pc, 32'h8);
    chk("full_pushpop_req", imem_req, 1'b1);
    chk("full_pushpop_addr", imem_addr, 32'h14);
    tick;
    chk("rel_pc3", out_pc, 32'hC);
    tick;
    chk("rel_pc4", out_pc, 32'h10);

    // Late ack with redirect during the wait -> DRAIN
    redirect = 1'b1; redirect_pc = 32'h8; lat = 3;
    tick;
    redirect = 1'b0;
    chk("rd8_flush", out_valid, 1'b0);
    tick;
    chk("rd8_req", imem_req, 1'b1);
    chk("rd8_addr", imem_addr, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick;
    redirect = 1'b0;
    chk("drain_req", imem_req, 1'b1);
    chk("drain_addr1", imem_addr, 32'h8);
    tick;
    chk("drain_addr2", imem_addr, 32'h8);
    chk("drain_valid", out_valid, 1'b0);
    tick;
    chk("drain_addr3", imem_addr, 32'h8);
    tick;
    chk("drain_done_req", imem_req, 1'b0);
    chk("drain_dropped", out_valid, 1'b0);
    lat = 0;
    tick;
    chk("post_drain_req", imem_req, 1'b1);
    chk("post_drain_addr", imem_addr, 32'h100);
    tick;
    chk("post_drain_valid", out_valid, 1'b1);
    chk("post_drain_pc", out_pc, 32'h100);
    chk("post_drain_ir", out_ir, mem_word(32'h100));

    // Redirect coinciding with ack
    redirect = 1'b1; redirect_pc = 32'h200;
    tick;
    redirect = 1'b0;
    chk("coinc_empty", out_valid, 1'b0);
    chk("coinc_req", imem_req, 1'b0);
    tick;
    chk("coinc_addr", imem_addr, 32'h200);
    tick;
    chk("coinc_pc", out_pc, 32'h200);

    // fetch_pc wraps at 2^32
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect = 1'b0;
    tick;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick;
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    chk("wrap_addr1", imem_addr, 32'h0);
    tick;
    chk("wrap_pc1", out_pc, 32'h0);

    // Scoreboard: 12 pops through a wrapping queue under a hold pattern
    redirect = 1'b1; redirect_pc = 32'h1000;
    tick;
    redirect = 1'b0;
    hpat = 16'b0101_0000_0011_1111;
    exp_pc = 32'h1000;
    pops = 0;
    for (int i = 0; i < 64 && pops < 12; i++) begin
      tick;
      hold = hpat[i % 16];
      if (out_valid && !hold) begin
        chk("sb_pc", out_pc, exp_pc);
        chk("sb_ir", out_ir, mem_word(exp_pc));
        exp_pc += 32'd4;
        pops++;
      end
    end
    hold = 1'b0;
    chk("sb_pops", 32'(pops), 32'd12);

    // Reset mid-request drops the transaction asynchronously
    lat = 5;
    redirect = 1'b1; redirect_pc = 32'h40;
    tick;
    redirect = 1'b0;
    tick;
    chk("mid_req", imem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_req", imem_req, 1'b0);
    chk("async_valid", out_valid, 1'b0);
    chk("async_addr", imem_addr, 32'h0);
    force_ack = 1'b1;
    tick(2);
    force_ack = 1'b0; lat = 0;
    tick(2);
    chk("rst2_valid", out_valid, 1'b0);
    reset = 1'b1;
    tick;
    chk("rst2_req", imem_req, 1'b1);
    chk("rst2_addr", imem_addr, 32'h0);
    tick;
    chk("rst2_pc", out_pc, 32'h0);
    chk("rst2_valid2", out_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
